// File: rtl/mem_line_requester.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : mem_line_requester
// Brief   : Cache-miss sequencer for the 128-bit slow-memory line protocol:
//           optional dirty-victim write-back, then line fill, with timeout.
// Revision: 1.0 - initial release
// ============================================================================
module mem_line_requester #(
  parameter int TIMEOUT_CYC = 1023,
  parameter int CNT_W       = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  input  logic [27:0]  req_addr,
  input  logic         req_dirty,
  input  logic [27:0]  victim_addr,
  input  logic [127:0] victim_data,
  output logic         busy,
  output logic         done,
  output logic [127:0] fill_data,
  output logic         err,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WB     = 3'd1,
    S_WB_GAP = 3'd2,
    S_RD     = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYC);

  state_t         r_state, w_state_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_done, w_done_nxt;
  logic           r_err, w_err_nxt;
  logic           r_mem_read, w_mem_read_nxt;
  logic           r_mem_write, w_mem_write_nxt;
  logic [27:0]    r_mem_addr, w_mem_addr_nxt;
  logic [127:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [127:0]   r_fill_data, w_fill_data_nxt;
  logic [27:0]    r_fill_addr, w_fill_addr_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic           w_timeout;

  // Saturating wait counter; a zero TIMEOUT_CYC disables the timeout.
  assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_one;
  assign w_timeout = (TIMEOUT_CYC != 0) && (w_cnt_inc == c_timeout);

  always_comb begin
    w_state_nxt     = r_state;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_err_nxt       = r_err;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_fill_data_nxt = r_fill_data;
    w_fill_addr_nxt = r_fill_addr;
    w_cnt_nxt       = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_busy_nxt      = 1'b1;
          w_fill_addr_nxt = req_addr;
          w_cnt_nxt       = '0;
          if (req_dirty) begin
            w_state_nxt     = S_WB;
            w_mem_write_nxt = 1'b1;
            w_mem_addr_nxt  = victim_addr;
            w_mem_wdata_nxt = victim_data;
          end else begin
            w_state_nxt    = S_RD;
            w_mem_read_nxt = 1'b1;
            w_mem_addr_nxt = req_addr;
          end
        end
      end

      S_WB: begin
        if (mem_ready) begin
          w_mem_write_nxt = 1'b0;
          w_state_nxt     = S_WB_GAP;
        end else if (w_timeout) begin
          w_mem_write_nxt = 1'b0;
          w_err_nxt       = 1'b1;
          w_done_nxt      = 1'b1;
          w_state_nxt     = S_DONE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      // One idle cycle so the memory sees the write request drop.
      S_WB_GAP: begin
        w_mem_read_nxt = 1'b1;
        w_mem_addr_nxt = r_fill_addr;
        w_cnt_nxt      = '0;
        w_state_nxt    = S_RD;
      end

      S_RD: begin
        if (mem_ready) begin
          w_mem_read_nxt  = 1'b0;
          w_fill_data_nxt = mem_rdata;
          w_done_nxt      = 1'b1;
          w_state_nxt     = S_DONE;
        end else if (w_timeout) begin
          w_mem_read_nxt = 1'b0;
          w_err_nxt      = 1'b1;
          w_done_nxt     = 1'b1;
          w_state_nxt    = S_DONE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_busy_nxt      = 1'b0;
        w_mem_read_nxt  = 1'b0;
        w_mem_write_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_fill_data <= '0;
      r_fill_addr <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_fill_data <= w_fill_data_nxt;
      r_fill_addr <= w_fill_addr_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign fill_data = r_fill_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_line_requester.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_mem_line_requester
// Brief   : Self-checking bench: latency-programmable memory responder,
//           vector table, corner sequences and randomized misses.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_line_requester;

  localparam int c_to = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [27:0]  req_addr = '0;
  logic         req_dirty = 1'b0;
  logic [27:0]  victim_addr = '0;
  logic [127:0] victim_data = '0;
  logic         busy, done, err, mem_read, mem_write;
  logic [127:0] fill_data, mem_wdata;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  always #5 clk = ~clk;

  mem_line_requester #(.TIMEOUT_CYC(c_to), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_dirty(req_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
    .busy(busy), .done(done), .fill_data(fill_data), .err(err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_vec = 0;
  int n_miss = 0;
  int lat_w = 1;
  int lat_r = 1;
  bit spurious = 1'b0;
  int rsp_k = 0;
  int rsp_l = 0;
  logic [127:0] mem [logic [27:0]];
  logic [127:0] model_fill = '0;
  logic         model_err = 1'b0;

  typedef struct {
    logic         dirty;
    logic [27:0]  raddr;
    logic [27:0]  vaddr;
    logic [127:0] vdata;
    int           lw;
    int           lr;
    int           exp_done;
    logic         exp_err;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [127:0] init_line(input logic [27:0] a);
    return {16'hC0DE, a, ~a, a ^ 28'h5A5A5A5, a + 28'h1234567};
  endfunction

  function automatic logic [127:0] mem_rd(input logic [27:0] a);
    if (mem.exists(a)) return mem[a];
    return init_line(a);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Memory: holds ready off until the request has been up lat cycles (0 = never).
  initial begin : responder
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (!rst_n) begin
        rsp_k = 0;
      end else if (mem_read || mem_write) begin
        rsp_k++;
        rsp_l = mem_write ? lat_w : lat_r;
        if (rsp_l != 0 && rsp_k == rsp_l) begin
          mem_ready = 1'b1;
          rsp_k = 0;
          if (mem_write) mem[mem_addr] = mem_wdata;
          else mem_rdata = mem_rd(mem_addr);
        end
      end else begin
        rsp_k = 0;
        mem_ready = spurious && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Transaction-level timing: accept cycle, write hold, gap, read hold, done.
  task automatic model_expect(input logic dirty, input int lw, input int lr,
                              output int done_idx, output int wc, output int rc,
                              output logic to);
    logic w_to, r_to;
    w_to = dirty && !(lw >= 1 && lw <= c_to);
    r_to = !w_to && !(lr >= 1 && lr <= c_to);
    wc = dirty ? (w_to ? c_to : lw) : 0;
    rc = w_to ? 0 : (r_to ? c_to : lr);
    to = w_to || r_to;
    done_idx = wc + ((dirty && !w_to) ? 1 : 0) + rc + 1;
  endtask

  task automatic run_miss(input logic dirty, input logic [27:0] raddr, input logic [27:0] vaddr,
                          input logic [127:0] vdata, input int lw, input int lr,
                          input int exp_done, input logic exp_err, input string tag);
    int m_done, wc, rc, got_done, n_w, n_r, bad;
    logic to;
    logic [127:0] exp_fill;
    model_expect(dirty, lw, lr, m_done, wc, rc, to);
    exp_fill = to ? model_fill : ((dirty && vaddr == raddr) ? vdata : mem_rd(raddr));
    lat_w = lw;
    lat_r = lr;
    @(negedge clk);
    req_valid = 1'b1; req_dirty = dirty; req_addr = raddr;
    victim_addr = vaddr; victim_data = vdata;
    got_done = -1; n_w = 0; n_r = 0; bad = 0;
    for (int idx = 1; idx <= 60; idx++) begin
      @(negedge clk);
      if (idx == 1) begin
        req_valid = 1'b0; req_dirty = 1'($urandom); req_addr = 28'($urandom);
        victim_addr = 28'($urandom); victim_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (mem_write) begin
        n_w++;
        if (mem_addr !== vaddr || mem_wdata !== vdata) bad++;
      end
      if (mem_read) begin
        n_r++;
        if (mem_addr !== raddr) bad++;
      end
      if (mem_read && mem_write) bad++;
      if (busy !== 1'b1) bad++;
      if (done === 1'b1) begin
        got_done = idx;
        break;
      end
    end
    check({tag, ".done_cycle"}, got_done, exp_done);
    check({tag, ".write_cycles"}, n_w, wc);
    check({tag, ".read_cycles"}, n_r, rc);
    check({tag, ".protocol"}, bad, 0);
    check({tag, ".fill"}, fill_data, exp_fill);
    check({tag, ".err"}, err, exp_err);
    @(negedge clk);
    check({tag, ".idle_after"}, {busy, done, mem_read, mem_write}, 4'b0000);
    if (to) model_err = 1'b1;
    else model_fill = exp_fill;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [27:0]  a_addr, b_addr;
    logic [127:0] exp_a, exp_b;
    int got, bad, m_done, wc, rc, lw, lr;
    logic to, dirty;
    logic [27:0] ra, va;

    tbl[0] = '{1'b0, 28'h0000100, 28'h0, 128'h0, 0, 5, 6, 1'b0};
    tbl[1] = '{1'b1, 28'h0000020, 28'h0000010, 128'hDEADBEEF_01234567_89ABCDEF_FEEDF00D, 3, 4, 9, 1'b0};
    tbl[2] = '{1'b0, 28'h0000030, 28'h0, 128'h0, 0, 1, 2, 1'b0};
    tbl[3] = '{1'b1, 28'h0000041, 28'h0000040, 128'h11112222_33334444_55556666_77778888, 1, 1, 4, 1'b0};
    tbl[4] = '{1'b1, 28'h0000ABC, 28'h0000ABC, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 2, 2, 6, 1'b0};
    tbl[5] = '{1'b0, 28'h0000010, 28'h0, 128'h0, 0, 2, 3, 1'b0};
    tbl[6] = '{1'b0, 28'h0000050, 28'h0, 128'h0, 0, 16, 17, 1'b0};
    tbl[7] = '{1'b1, 28'h0000061, 28'h0000060, 128'hCAFEBABE_00000001_00000002_00000003, 16, 1, 19, 1'b0};
    tbl[8] = '{1'b0, 28'h0000070, 28'h0, 128'h0, 0, 0, 17, 1'b1};
    tbl[9] = '{1'b1, 28'h0000081, 28'h0000080, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 0, 3, 17, 1'b1};

    repeat (3) @(negedge clk);
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.err", err, 1'b0);
    check("reset.mem_read", mem_read, 1'b0);
    check("reset.mem_write", mem_write, 1'b0);
    check("reset.mem_addr", mem_addr, 28'h0);
    check("reset.mem_wdata", mem_wdata, 128'h0);
    check("reset.fill_data", fill_data, 128'h0);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_miss(tbl[i].dirty, tbl[i].raddr, tbl[i].vaddr, tbl[i].vdata, tbl[i].lw,
               tbl[i].lr, tbl[i].exp_done, tbl[i].exp_err, $sformatf("tbl%0d", i));

    // Reset in the middle of a read that would otherwise never complete.
    lat_r = 0;
    @(negedge clk);
    req_valid = 1'b1; req_dirty = 1'b0; req_addr = 28'h0000777;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid.pre_read", mem_read, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.mem_read", mem_read, 1'b0);
    check("rst_mid.busy", busy, 1'b0);
    check("rst_mid.fill_data", fill_data, 128'h0);
    check("rst_mid.err", err, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    model_fill = '0;
    model_err = 1'b0;
    run_miss(1'b0, 28'h0000778, 28'h0, 128'h0, 0, 3, 4, 1'b0, "post_rst");

    // req_valid held high and req_addr changed after accept.
    a_addr = 28'h0000500;
    b_addr = 28'h0000600;
    exp_a = mem_rd(a_addr);
    exp_b = mem_rd(b_addr);
    lat_r = 2;
    @(negedge clk);
    req_valid = 1'b1; req_dirty = 1'b0; req_addr = a_addr;
    @(negedge clk);
    req_addr = b_addr;
    got = -1; bad = 0;
    for (int i = 1; i <= 20; i++) begin
      if (mem_read && mem_addr !== a_addr) bad++;
      if (done) begin got = i; break; end
      @(negedge clk);
    end
    check("hold.done_cycle", got, 3);
    check("hold.latched_addr", bad, 0);
    check("hold.fill", fill_data, exp_a);
    @(negedge clk);
    check("hold.idle_gap", {busy, done, mem_read}, 3'b000);
    @(negedge clk);
    check("hold.reaccept", {busy, mem_read, mem_addr}, {1'b1, 1'b1, b_addr});
    req_valid = 1'b0;
    got = -1;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin got = i; break; end
      @(negedge clk);
    end
    check("hold.done2_cycle", got, 3);
    check("hold.fill2", fill_data, exp_b);
    model_fill = exp_b;
    @(negedge clk);

    // Randomized misses with spurious ready pulses while no request is up.
    spurious = 1'b1;
    for (int i = 0; i < 40; i++) begin
      dirty = 1'($urandom_range(0, 1));
      ra = 28'h0001230 + 28'($urandom_range(0, 7));
      va = 28'h0001230 + 28'($urandom_range(0, 7));
      lw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 18) : $urandom_range(1, 6);
      lr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 18) : $urandom_range(1, 6);
      model_expect(dirty, lw, lr, m_done, wc, rc, to);
      run_miss(dirty, ra, va, {$urandom, $urandom, $urandom, $urandom}, lw, lr,
               m_done, model_err || to, $sformatf("rnd%0d", i));
    end
    spurious = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
